// File: rtl/prince_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prince_ctrl_pkg
// Description : Shared types and constants for the PRINCE round controller.
// Revision    : 1.0 - initial release
// ============================================================================
package prince_ctrl_pkg;

    localparam int NUM_LAYERS       = 12;
    localparam int SBOX_LAT_DEFAULT = 4;
    localparam int FWD_LAYERS       = NUM_LAYERS / 2;

    localparam logic [3:0] LAST_LAYER = 4'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LIN   = 3'd4,
        ST_FINAL = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        LIN_NONE = 2'd0,
        LIN_M    = 2'd1,
        LIN_MP   = 2'd2,
        LIN_MINV = 2'd3
    } lin_sel_e;

endpackage : prince_ctrl_pkg
`default_nettype wire

// File: rtl/prince_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : prince_round_ctrl_if
// Description : Control bundle between the round controller and the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface prince_round_ctrl_if;
    import prince_ctrl_pkg::*;

    logic       start;
    logic       rand_valid;
    logic       rand_req;
    logic       state_load;
    logic       state_we;
    logic       sbox_sel;
    lin_sel_e   lin_sel;
    logic       rc_en;
    logic [3:0] rc_idx;
    logic       out_we;
    logic       busy;
    logic       done;

    // The controller is the master of the masked datapath.
    modport master (
        input  start, rand_valid,
        output rand_req, state_load, state_we, sbox_sel, lin_sel,
               rc_en, rc_idx, out_we, busy, done
    );

    modport slave (
        output start, rand_valid,
        input  rand_req, state_load, state_we, sbox_sel, lin_sel,
               rc_en, rc_idx, out_we, busy, done
    );

endinterface : prince_round_ctrl_if
`default_nettype wire

// File: rtl/prince_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prince_round_ctrl
// Description : Layer sequencer for a masked PRINCE core (6 forward + 6 inverse
//               S-box layers, pipelined S-box with SBOX_LAT cycles latency).
// Revision    : 1.0 - initial release
// ============================================================================
module prince_round_ctrl
    import prince_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = SBOX_LAT_DEFAULT   // legal range 2..15
) (
    input  wire logic           clk,
    input  wire logic           rst,
    prince_round_ctrl_if.master ctrl
);

    // WAIT covers SBOX_LAT-1 cycles; the counter runs down to zero.
    localparam logic [3:0] c_wait_init   = 4'(SBOX_LAT - 2);
    localparam logic [3:0] c_mprime_layer = 4'(FWD_LAYERS - 1);
    localparam logic [3:0] c_inv_first    = 4'(FWD_LAYERS);

    state_e     r_state;
    state_e     w_next_state;
    logic [3:0] r_layer;
    logic [3:0] r_wait_cnt;

    logic       w_inv_half;
    logic       w_rand_req;
    logic       w_state_load;
    logic       w_state_we;
    logic       w_sbox_sel;
    lin_sel_e   w_lin_sel;
    logic       w_rc_en;
    logic [3:0] w_rc_idx;
    logic       w_out_we;
    logic       w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_layer    <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_LOAD:  r_layer <= '0;
                ST_ISSUE: if (ctrl.rand_valid) r_wait_cnt <= c_wait_init;
                ST_WAIT:  if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - 4'd1;
                ST_LIN:   if (r_layer != LAST_LAYER) r_layer <= r_layer + 4'd1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (ctrl.start) w_next_state = ST_LOAD;
            ST_LOAD:  w_next_state = ST_ISSUE;
            ST_ISSUE: if (ctrl.rand_valid) w_next_state = ST_WAIT;
            ST_WAIT:  if (r_wait_cnt == '0) w_next_state = ST_LIN;
            ST_LIN:   w_next_state = (r_layer == LAST_LAYER) ? ST_FINAL : ST_ISSUE;
            ST_FINAL: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    assign w_inv_half = (r_layer >= c_inv_first);

    always_comb begin
        w_rand_req   = 1'b0;
        w_state_load = 1'b0;
        w_state_we   = 1'b0;
        w_sbox_sel   = 1'b0;
        w_lin_sel    = LIN_NONE;
        w_rc_en      = 1'b0;
        w_rc_idx     = '0;
        w_out_we     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_state_load = 1'b1;
                w_rc_en      = 1'b1;
            end
            ST_ISSUE: begin
                w_rand_req = 1'b1;
                w_sbox_sel = w_inv_half;
            end
            ST_WAIT: w_sbox_sel = w_inv_half;
            ST_LIN: begin
                // The last layer's result goes straight to output whitening.
                if (r_layer < c_mprime_layer) begin
                    w_state_we = 1'b1;
                    w_lin_sel  = LIN_M;
                    w_rc_en    = 1'b1;
                    w_rc_idx   = r_layer + 4'd1;
                end else if (r_layer == c_mprime_layer) begin
                    w_state_we = 1'b1;
                    w_lin_sel  = LIN_MP;
                end else if (r_layer < LAST_LAYER) begin
                    w_state_we = 1'b1;
                    w_lin_sel  = LIN_MINV;
                    w_rc_en    = 1'b1;
                    w_rc_idx   = r_layer;
                end
            end
            ST_FINAL: begin
                w_rc_en  = 1'b1;
                w_rc_idx = LAST_LAYER;
                w_out_we = 1'b1;
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    assign ctrl.rand_req   = w_rand_req;
    assign ctrl.state_load = w_state_load;
    assign ctrl.state_we   = w_state_we;
    assign ctrl.sbox_sel   = w_sbox_sel;
    assign ctrl.lin_sel    = w_lin_sel;
    assign ctrl.rc_en      = w_rc_en;
    assign ctrl.rc_idx     = w_rc_idx;
    assign ctrl.out_we     = w_out_we;
    assign ctrl.busy       = (r_state != ST_IDLE);
    assign ctrl.done       = w_done;

endmodule : prince_round_ctrl
`default_nettype wire

// File: tb/tb_prince_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prince_round_ctrl
// Description : Checks two controller instances (SBOX_LAT 4 and 2) against a
//               planned-trace reference model under directed and random input.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prince_round_ctrl;
    import prince_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prince_round_ctrl_if ifa ();
    prince_round_ctrl_if ifb ();

    prince_round_ctrl #(.SBOX_LAT(4)) dut_a (.clk(clk), .rst(rst), .ctrl(ifa));
    prince_round_ctrl #(.SBOX_LAT(2)) dut_b (.clk(clk), .rst(rst), .ctrl(ifb));

    // One entry per expected cycle of an operation; ISSUE entries repeat while
    // no randomness is offered.
    typedef struct {
        logic [13:0] v;
        bit          issue;
    } step_t;

    step_t qa[$];
    step_t qb[$];

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    bit known  = 0;
    int done_a = -1;
    int done_b = -1;
    int rr_a   = 0;
    int ndone_a = 0;

    // {rand_req, state_load, state_we, sbox_sel, lin_sel, rc_en, rc_idx, out_we, busy, done}
    function automatic logic [13:0] mk(bit rr, bit sl, bit sw, bit ss, logic [1:0] ls,
                                       bit re, int ri, bit ow, bit dn);
        return {rr, sl, sw, ss, ls, re, 4'(ri), ow, 1'b1, dn};
    endfunction

    function automatic logic [13:0] obs_a();
        return {ifa.rand_req, ifa.state_load, ifa.state_we, ifa.sbox_sel, 2'(ifa.lin_sel),
                ifa.rc_en, ifa.rc_idx, ifa.out_we, ifa.busy, ifa.done};
    endfunction

    function automatic logic [13:0] obs_b();
        return {ifb.rand_req, ifb.state_load, ifb.state_we, ifb.sbox_sel, 2'(ifb.lin_sel),
                ifb.rc_en, ifb.rc_idx, ifb.out_we, ifb.busy, ifb.done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic put(input int inst, input logic [13:0] v, input bit issue);
        step_t s;
        s.v     = v;
        s.issue = issue;
        if (inst == 0) qa.push_back(s);
        else           qb.push_back(s);
    endtask

    // Whole-operation plan: load, 12 x (issue, wait, linear), final, done.
    task automatic plan(input int inst, input int lat);
        bit         inv;
        logic [1:0] ls;
        bit         en, we;
        int         ri;
        put(inst, mk(0, 1, 0, 0, 2'd0, 1, 0, 0, 0), 0);
        for (int l = 0; l < NUM_LAYERS; l++) begin
            inv = (l >= NUM_LAYERS / 2);
            put(inst, mk(1, 0, 0, inv, 2'd0, 0, 0, 0, 0), 1);
            for (int w = 0; w < lat - 1; w++)
                put(inst, mk(0, 0, 0, inv, 2'd0, 0, 0, 0, 0), 0);
            if (l < NUM_LAYERS / 2 - 1) begin
                ls = 2'd1; en = 1; ri = l + 1; we = 1;
            end else if (l == NUM_LAYERS / 2 - 1) begin
                ls = 2'd2; en = 0; ri = 0; we = 1;
            end else if (l < NUM_LAYERS - 1) begin
                ls = 2'd3; en = 1; ri = l; we = 1;
            end else begin
                ls = 2'd0; en = 0; ri = 0; we = 0;
            end
            put(inst, mk(0, 0, we, 0, ls, en, ri, 0, 0), 0);
        end
        put(inst, mk(0, 0, 0, 0, 2'd0, 1, NUM_LAYERS - 1, 1, 0), 0);
        put(inst, mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 1), 0);
    endtask

    // Observe the current cycle, then drive inputs for the next edge.
    task automatic tick(input logic s, input logic rv, input logic r);
        @(negedge clk);
        if (known) begin
            chk("trace_lat4", 32'(obs_a()), 32'((qa.size() == 0) ? 14'd0 : qa[0].v));
            chk("trace_lat2", 32'(obs_b()), 32'((qb.size() == 0) ? 14'd0 : qb[0].v));
            if (ifa.done === 1'b1) begin done_a = cyc; ndone_a++; end
            if (ifb.done === 1'b1) done_b = cyc;
            if (ifa.rand_req === 1'b1) rr_a++;
        end
        rst = r;
        ifa.start = s;  ifb.start = s;
        ifa.rand_valid = rv;  ifb.rand_valid = rv;
        if (r) begin
            qa.delete();
            qb.delete();
            known = 1;
        end else begin
            if (qa.size() == 0) begin
                if (s) plan(0, 4);
            end else if (!(qa[0].issue && !rv)) begin
                void'(qa.pop_front());
            end
            if (qb.size() == 0) begin
                if (s) plan(1, 2);
            end else if (!(qb[0].issue && !rv)) begin
                void'(qb.pop_front());
            end
        end
        cyc++;
    endtask

    int t0;

    initial begin
        ifa.start = 0; ifb.start = 0;
        ifa.rand_valid = 0; ifb.rand_valid = 0;

        tick(0, 0, 1);
        tick(0, 0, 1);
        repeat (3) tick(0, 1, 0);

        // Nominal operation with randomness always available
        done_a = -1; done_b = -1; rr_a = 0;
        t0 = cyc;
        tick(1, 1, 0);
        repeat (70) tick(0, 1, 0);
        chk("lat4_done_cycle", 32'(done_a - t0), 32'd63);
        chk("lat2_done_cycle", 32'(done_b - t0), 32'd39);
        chk("lat4_rand_req_cnt", 32'(rr_a), 32'd12);

        // Seven-cycle randomness stall during the third ISSUE
        done_a = -1;
        t0 = cyc;
        tick(1, 1, 0);
        for (int k = 1; k <= 80; k++) tick(0, !(k >= 12 && k < 19), 0);
        chk("lat4_stall_done_cycle", 32'(done_a - t0), 32'd70);

        // Abort during WAIT of layer 8, then a clean restart
        done_a = -1;
        tick(1, 1, 0);
        for (int k = 1; k <= 43; k++) tick(0, 1, 0);
        tick(0, 1, 1);
        repeat (10) tick(0, 1, 0);
        chk("abort_no_done", 32'(done_a), 32'hFFFF_FFFF);
        t0 = cyc;
        tick(1, 1, 0);
        repeat (70) tick(0, 1, 0);
        chk("restart_done_cycle", 32'(done_a - t0), 32'd63);

        // start held high: back-to-back operations, period 64
        ndone_a = 0;
        repeat (200) tick(1, 1, 0);
        chk("b2b_done_cnt", 32'(ndone_a), 32'd3);
        tick(0, 1, 1);

        // Random traffic with occasional resets
        repeat (3000)
            tick($urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 499) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_prince_round_ctrl
`default_nettype wire
